// File: rtl/udp_pkg.sv
// Shared types for the UDP transmit arbiter: FSM states and the latched header record.
package udp_pkg;

  localparam int UDP_HDR_FIELD_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } udp_arb_state_t;

  typedef struct packed {
    logic [UDP_HDR_FIELD_W-1:0] src_port;
    logic [UDP_HDR_FIELD_W-1:0] dst_port;
    logic [UDP_HDR_FIELD_W-1:0] length;
    logic [UDP_HDR_FIELD_W-1:0] checksum;
  } udp_hdr_t;

endpackage

// File: rtl/udp_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first request at or after ptr_i, wrapping modulo N.
// There is no state or latency here; the caller owns the pointer and decides when to advance it.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  always_comb begin
    int  j;
    logic found;
    j         = 0;
    found     = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[IW'(j)]) begin
        found               = 1'b1;
        gnt_oh_o[IW'(j)]    = 1'b1;
        gnt_idx_o           = IW'(j);
      end
    end
    gnt_vld_o = found;
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin share of one UDP tx path: header out 1 cycle after accept, payload muxed with zero latency.
// Grant holds until tlast; downstream ready feeds back only to the granted lane. Option: UDP_TX_ARB_PKT_CNT_EN.
module udp_tx_arbiter
  import udp_pkg::*;
#(
  parameter  int AXI_DATA_WIDTH = 8,
  parameter  int NUM_PORTS      = 4,
  localparam int IDX_W          = $clog2(NUM_PORTS)
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic [NUM_PORTS-1:0]                s_udp_hdr_tvalid,
  output logic [NUM_PORTS-1:0]                s_udp_hdr_trdy,
  input  logic [16*NUM_PORTS-1:0]             s_udp_src_port,
  input  logic [16*NUM_PORTS-1:0]             s_udp_dst_port,
  input  logic [16*NUM_PORTS-1:0]             s_udp_length,
  input  logic [16*NUM_PORTS-1:0]             s_udp_checksum,
  input  logic [AXI_DATA_WIDTH*NUM_PORTS-1:0] s_tx_axis_tdata,
  input  logic [NUM_PORTS-1:0]                s_tx_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                s_tx_axis_tlast,
  output logic [NUM_PORTS-1:0]                s_tx_axis_trdy,
  output logic                                m_udp_hdr_tvalid,
  input  logic                                m_udp_hdr_trdy,
  output logic [15:0]                         m_udp_src_port,
  output logic [15:0]                         m_udp_dst_port,
  output logic [15:0]                         m_udp_length,
  output logic [15:0]                         m_udp_hdr_checksum,
  output logic [AXI_DATA_WIDTH-1:0]           m_tx_axis_tdata,
  output logic                                m_tx_axis_tvalid,
  output logic                                m_tx_axis_tlast,
  input  logic                                m_tx_axis_trdy,
`ifdef UDP_TX_ARB_PKT_CNT_EN
  output logic [16*NUM_PORTS-1:0]             o_pkt_cnt,
`endif
  output logic [IDX_W-1:0]                    o_grant
);

  udp_arb_state_t   state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  udp_hdr_t         hdr_q, hdr_d;
  logic             hdr_vld_q, hdr_vld_d;

  logic [NUM_PORTS-1:0]                     arb_oh;
  logic [IDX_W-1:0]                         arb_idx;
  logic                                     arb_vld;
  logic [NUM_PORTS-1:0][15:0]               src_a, dst_a, len_a, csum_a;
  logic [NUM_PORTS-1:0][AXI_DATA_WIDTH-1:0] tdata_a;

  assign src_a   = s_udp_src_port;
  assign dst_a   = s_udp_dst_port;
  assign len_a   = s_udp_length;
  assign csum_a  = s_udp_checksum;
  assign tdata_a = s_tx_axis_tdata;

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .req_i     (s_udp_hdr_tvalid),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    grant_d          = grant_q;
    hdr_d            = hdr_q;
    hdr_vld_d        = hdr_vld_q;
    s_udp_hdr_trdy   = '0;
    s_tx_axis_trdy   = '0;
    m_tx_axis_tdata  = '0;
    m_tx_axis_tvalid = 1'b0;
    m_tx_axis_tlast  = 1'b0;
    case (state_q)
      IDLE: begin
        s_udp_hdr_trdy = arb_oh;
        if (arb_vld) begin
          hdr_d.src_port = src_a[arb_idx];
          hdr_d.dst_port = dst_a[arb_idx];
          hdr_d.length   = len_a[arb_idx];
          hdr_d.checksum = csum_a[arb_idx];
          grant_d        = arb_idx;
          hdr_vld_d      = 1'b1;
          state_d        = HDR;
        end
      end
      HDR: begin
        if (m_udp_hdr_trdy) begin
          hdr_vld_d = 1'b0;
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        m_tx_axis_tdata         = tdata_a[grant_q];
        m_tx_axis_tvalid        = s_tx_axis_tvalid[grant_q];
        m_tx_axis_tlast         = s_tx_axis_tlast[grant_q];
        s_tx_axis_trdy[grant_q] = m_tx_axis_trdy;
        if (s_tx_axis_tvalid[grant_q] && m_tx_axis_trdy && s_tx_axis_tlast[grant_q]) begin
          // Just-served requester drops to lowest priority.
          rr_ptr_d = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      hdr_q     <= '0;
      hdr_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      hdr_q     <= hdr_d;
      hdr_vld_q <= hdr_vld_d;
    end
  end

  assign m_udp_hdr_tvalid   = hdr_vld_q;
  assign m_udp_src_port     = hdr_q.src_port;
  assign m_udp_dst_port     = hdr_q.dst_port;
  assign m_udp_length       = hdr_q.length;
  assign m_udp_hdr_checksum = hdr_q.checksum;
  assign o_grant            = grant_q;

`ifdef UDP_TX_ARB_PKT_CNT_EN
  logic [NUM_PORTS-1:0][15:0] pkt_cnt_q;
  logic                       pkt_done;

  assign pkt_done  = (state_q == PAYLOAD) && m_tx_axis_tvalid && m_tx_axis_trdy && m_tx_axis_tlast;
  assign o_pkt_cnt = pkt_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pkt_cnt_q <= '0;
    end else if (pkt_done) begin
      pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 16'd1;
    end
  end
`endif

endmodule
